// File: rtl/cnn_conv_quad_lite.sv
// Purpose: loads K*9 weight words and an RxC frame, then emits a 3x3 stride-1 conv result per (row, col, kernel).
// Latency: 10 COMPUTE cycles (9 taps + saturate) plus one RESULT cycle, so 11 cycles/result with result_accept high.
// Backpressure: load streams are ready only in their load state; RESULT holds data and indices until result_accept.
module cnn_conv_quad_lite #(
    parameter int MAX_ROWS    = 32,
    parameter int MAX_COLS    = 32,
    parameter int MAX_KERNELS = 8,
    parameter int FRAC_BITS   = 8
) (
    input  logic         clk_core,
    input  logic         rst_n,
    input  logic         job_start,
    input  logic [127:0] job_parameters,
    output logic         job_accept,
    output logic         job_fetch_request,
    input  logic         job_fetch_ack,
    output logic         job_fetch_complete,
    output logic         job_complete,
    input  logic         job_complete_ack,
    input  logic         weight_valid,
    output logic         weight_ready,
    input  logic [127:0] weight_data,
    input  logic         pixel_valid,
    output logic         pixel_ready,
    input  logic [127:0] pixel_data,
    output logic         result_valid,
    input  logic         result_accept,
    output logic [15:0]  result_data,
    output logic [7:0]   output_row,
    output logic [7:0]   output_col,
    output logic [7:0]   output_depth
);

    localparam int PIX_DEPTH = MAX_ROWS * MAX_COLS;
    localparam int WGT_DEPTH = MAX_KERNELS * 9;
    localparam int PA_W      = $clog2(PIX_DEPTH);
    localparam int WA_W      = $clog2(WGT_DEPTH);
    localparam logic [7:0] MAX_R = 8'(MAX_ROWS);
    localparam logic [7:0] MAX_C = 8'(MAX_COLS);
    localparam logic [7:0] MAX_K = 8'(MAX_KERNELS);

    typedef struct packed {
        logic [7:0] kernels;
        logic [7:0] cols;
        logic [7:0] rows;
    } job_cfg_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_FETCH, S_LOAD_W, S_LOAD_P, S_COMPUTE, S_RESULT, S_DONE
    } state_t;

    state_t state_q, state_d;
    job_cfg_t cfg_q, cfg_in;
    logic [15:0] w_cnt_q, p_cnt_q, w_total, p_total;
    logic [3:0]  tap_q;
    logic [7:0]  orow_q, ocol_q, okern_q;
    logic signed [39:0] acc_q, tap_sum, acc_shr;
    logic [15:0] res_q, res_sat;
    logic        fetch_done_q;

    logic [127:0] wgt_mem [WGT_DEPTH];
    logic [127:0] pix_mem [PIX_DEPTH];
    logic [127:0] wgt_word, pix_word;
    logic signed [31:0] prod [8];
    logic [1:0]  tap_row, tap_col;
    logic [15:0] pix_addr, wgt_addr;

    logic weight_xfer, pixel_xfer, result_xfer;
    logic last_weight, last_pixel, last_out, cfg_ok;
    logic unused_bits;

    assign cfg_in      = job_parameters[23:0];
    assign unused_bits = ^{job_parameters[127:24], pix_addr[15:PA_W], wgt_addr[15:WA_W]};

    assign w_total = {8'd0, cfg_q.kernels} * 16'd9;
    assign p_total = {8'd0, cfg_q.rows} * {8'd0, cfg_q.cols};

    assign weight_xfer = weight_valid & weight_ready;
    assign pixel_xfer  = pixel_valid & pixel_ready;
    assign result_xfer = result_valid & result_accept;
    assign last_weight = (w_cnt_q == w_total - 16'd1);
    assign last_pixel  = (p_cnt_q == p_total - 16'd1);
    assign last_out    = (okern_q == cfg_q.kernels - 8'd1) &&
                         (ocol_q == cfg_q.cols - 8'd3) &&
                         (orow_q == cfg_q.rows - 8'd3);

    assign cfg_ok = (cfg_q.rows >= 8'd3) && (cfg_q.rows <= MAX_R) &&
                    (cfg_q.cols >= 8'd3) && (cfg_q.cols <= MAX_C) &&
                    (cfg_q.kernels != 8'd0) && (cfg_q.kernels <= MAX_K);

    // Tap t = kr*3 + kc selects the window offset within the 3x3 neighbourhood.
    always_comb begin
        tap_row = 2'd0;
        tap_col = 2'd0;
        case (tap_q)
            4'd1: tap_col = 2'd1;
            4'd2: tap_col = 2'd2;
            4'd3: tap_row = 2'd1;
            4'd4: begin tap_row = 2'd1; tap_col = 2'd1; end
            4'd5: begin tap_row = 2'd1; tap_col = 2'd2; end
            4'd6: tap_row = 2'd2;
            4'd7: begin tap_row = 2'd2; tap_col = 2'd1; end
            4'd8: begin tap_row = 2'd2; tap_col = 2'd2; end
            default: ;
        endcase
    end

    assign pix_addr = ({8'd0, orow_q} + {14'd0, tap_row}) * {8'd0, cfg_q.cols}
                    + {8'd0, ocol_q} + {14'd0, tap_col};
    assign wgt_addr = {8'd0, okern_q} * 16'd9 + {12'd0, tap_q};
    assign pix_word = pix_mem[pix_addr[PA_W-1:0]];
    assign wgt_word = wgt_mem[wgt_addr[WA_W-1:0]];

    always_comb begin
        tap_sum = '0;
        for (int i = 0; i < 8; i++) begin
            prod[i] = $signed(wgt_word[16*i +: 16]) * $signed(pix_word[16*i +: 16]);
            tap_sum = tap_sum + {{8{prod[i][31]}}, prod[i]};
        end
    end

    assign acc_shr = acc_q >>> FRAC_BITS;

    always_comb begin
        res_sat = acc_shr[15:0];
        if (acc_shr > 40'sd32767) begin
            res_sat = 16'h7fff;
        end else if (acc_shr < -40'sd32768) begin
            res_sat = 16'h8000;
        end
    end

    always_ff @(posedge clk_core) begin
        if (weight_xfer) begin
            wgt_mem[w_cnt_q[WA_W-1:0]] <= weight_data;
        end
        if (pixel_xfer) begin
            pix_mem[p_cnt_q[PA_W-1:0]] <= pixel_data;
        end
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        job_accept        = 1'b0;
        job_fetch_request = 1'b0;
        job_complete      = 1'b0;
        weight_ready      = 1'b0;
        pixel_ready       = 1'b0;
        result_valid      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (job_start) state_d = S_ACCEPT;
            end
            S_ACCEPT: begin
                job_accept = 1'b1;
                state_d    = cfg_ok ? S_FETCH : S_DONE;
            end
            S_FETCH: begin
                job_fetch_request = 1'b1;
                if (job_fetch_ack) state_d = S_LOAD_W;
            end
            S_LOAD_W: begin
                weight_ready = 1'b1;
                if (weight_xfer && last_weight) state_d = S_LOAD_P;
            end
            S_LOAD_P: begin
                pixel_ready = 1'b1;
                if (pixel_xfer && last_pixel) state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (tap_q == 4'd9) state_d = S_RESULT;
            end
            S_RESULT: begin
                result_valid = 1'b1;
                if (result_xfer) state_d = last_out ? S_DONE : S_COMPUTE;
            end
            S_DONE: begin
                job_complete = 1'b1;
                if (job_complete_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q        <= '0;
            w_cnt_q      <= '0;
            p_cnt_q      <= '0;
            tap_q        <= '0;
            orow_q       <= '0;
            ocol_q       <= '0;
            okern_q      <= '0;
            acc_q        <= '0;
            res_q        <= '0;
            fetch_done_q <= 1'b0;
        end else begin
            fetch_done_q <= pixel_xfer && last_pixel;
            case (state_q)
                S_IDLE: begin
                    if (job_start) begin
                        cfg_q   <= cfg_in;
                        w_cnt_q <= '0;
                        p_cnt_q <= '0;
                        tap_q   <= '0;
                        orow_q  <= '0;
                        ocol_q  <= '0;
                        okern_q <= '0;
                    end
                end
                S_LOAD_W: if (weight_xfer) w_cnt_q <= w_cnt_q + 16'd1;
                S_LOAD_P: if (pixel_xfer) p_cnt_q <= p_cnt_q + 16'd1;
                S_COMPUTE: begin
                    if (tap_q == 4'd9) begin
                        res_q <= res_sat;
                        tap_q <= 4'd0;
                    end else begin
                        acc_q <= (tap_q == 4'd0) ? tap_sum : acc_q + tap_sum;
                        tap_q <= tap_q + 4'd1;
                    end
                end
                S_RESULT: begin
                    // Kernel is the innermost loop, then column, then row.
                    if (result_xfer && !last_out) begin
                        if (okern_q == cfg_q.kernels - 8'd1) begin
                            okern_q <= '0;
                            if (ocol_q == cfg_q.cols - 8'd3) begin
                                ocol_q <= '0;
                                orow_q <= orow_q + 8'd1;
                            end else begin
                                ocol_q <= ocol_q + 8'd1;
                            end
                        end else begin
                            okern_q <= okern_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign job_fetch_complete = fetch_done_q;
    assign result_data        = res_q;
    assign output_row         = orow_q;
    assign output_col         = ocol_q;
    assign output_depth       = okern_q;

endmodule

// File: tb/tb_cnn_conv_quad_lite.sv
// Directed job sequence with randomized data/handshakes, checked against a loop-based convolution model.
module tb_cnn_conv_quad_lite;

    localparam int FRAC = 8;

    logic clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    logic         rst_n;
    logic         job_start;
    logic [127:0] job_parameters;
    logic         job_accept, job_fetch_request, job_fetch_ack, job_fetch_complete;
    logic         job_complete, job_complete_ack;
    logic         weight_valid, weight_ready;
    logic [127:0] weight_data;
    logic         pixel_valid, pixel_ready;
    logic [127:0] pixel_data;
    logic         result_valid, result_accept;
    logic [15:0]  result_data;
    logic [7:0]   output_row, output_col, output_depth;

    cnn_conv_quad_lite dut (
        .clk_core(clk_core), .rst_n(rst_n),
        .job_start(job_start), .job_parameters(job_parameters), .job_accept(job_accept),
        .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
        .job_fetch_complete(job_fetch_complete), .job_complete(job_complete),
        .job_complete_ack(job_complete_ack),
        .weight_valid(weight_valid), .weight_ready(weight_ready), .weight_data(weight_data),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_data(pixel_data),
        .result_valid(result_valid), .result_accept(result_accept), .result_data(result_data),
        .output_row(output_row), .output_col(output_col), .output_depth(output_depth)
    );

    typedef struct {
        int data;
        int row;
        int col;
        int k;
    } res_t;

    res_t         exp_q[$];
    logic [127:0] pix_img [1024];
    logic [127:0] wt_img  [72];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_res;

    always @(posedge clk_core) cyc++;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_core);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {17'd0, job_accept, job_fetch_request, job_fetch_complete, job_complete,
                weight_ready, pixel_ready, result_valid, result_data,
                output_row, output_col, output_depth};
    endfunction

    function automatic int lane(input logic [127:0] w, input int ch);
        logic signed [15:0] v;
        v = w[16*ch +: 16];
        return int'(v);
    endfunction

    function automatic logic [15:0] gen_val(input int mode, input bit is_wt, input int idx, input int ch);
        case (mode)
            0: return 16'h0100;
            1: return is_wt ? 16'($urandom_range(0, 1023)) - 16'd512
                            : 16'($urandom_range(0, 511)) - 16'd256;
            2: return (ch == 0) ? (is_wt ? 16'h0100 : 16'(idx + 1)) : 16'h0000;
            3: return 16'h7fff;
            4: return is_wt ? 16'h8000 : 16'h7fff;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic fill_images(input int mode, input int r, input int c, input int k);
        for (int i = 0; i < r * c; i++)
            for (int ch = 0; ch < 8; ch++) pix_img[i][16*ch +: 16] = gen_val(mode, 1'b0, i, ch);
        for (int i = 0; i < k * 9; i++)
            for (int ch = 0; ch < 8; ch++) wt_img[i][16*ch +: 16] = gen_val(mode, 1'b1, i, ch);
    endtask

    task automatic build_model(input int r, input int c, input int k);
        res_t   e;
        longint acc;
        exp_q.delete();
        for (int orow = 0; orow <= r - 3; orow++)
            for (int ocol = 0; ocol <= c - 3; ocol++)
                for (int kk = 0; kk < k; kk++) begin
                    acc = 0;
                    for (int kr = 0; kr < 3; kr++)
                        for (int kc = 0; kc < 3; kc++)
                            for (int ch = 0; ch < 8; ch++)
                                acc += longint'(lane(pix_img[(orow + kr) * c + ocol + kc], ch)) *
                                       longint'(lane(wt_img[kk * 9 + kr * 3 + kc], ch));
                    acc = acc >>> FRAC;
                    if (acc > 32767) acc = 32767;
                    if (acc < -32768) acc = -32768;
                    e.data = int'(acc);
                    e.row  = orow;
                    e.col  = ocol;
                    e.k    = kk;
                    exp_q.push_back(e);
                end
    endtask

    task automatic run_job(input int r, input int c, input int k, input int mode,
                           input bit rnd_acc, input int abort_at);
        int idx, guard, n, nres, last_xfer, d;
        bit stalled;
        logic [39:0] held, last_idx;
        res_t e;

        fill_images(mode, r, c, k);
        build_model(r, c, k);
        nres = exp_q.size();

        job_parameters = {$urandom, $urandom, $urandom, 8'($urandom), 8'(k), 8'(c), 8'(r)};
        job_start = 1'b1;
        tick;
        job_start = 1'b0;
        chk("accept_pulse", job_accept, 1);
        tick;
        chk("accept_once", job_accept, 0);

        d = $urandom_range(1, 3);
        for (int i = 0; i < d; i++) begin
            chk("fetch_req", job_fetch_request, 1);
            job_start = 1'b1;
            job_parameters = {$urandom, $urandom, $urandom, $urandom};
            tick;
            job_start = 1'b0;
            chk("busy_start_ignored", job_accept, 0);
        end
        job_fetch_ack = 1'b1;
        tick;
        job_fetch_ack = 1'b0;
        chk("fetch_req_drop", job_fetch_request, 0);

        idx = 0;
        guard = 0;
        pixel_valid = 1'b1;
        pixel_data = '1;
        while (idx < k * 9 && guard < 2000) begin
            if (guard == 0) chk("pix_rdy_in_loadw", pixel_ready, 0);
            weight_valid = ($urandom_range(0, 3) != 0);
            weight_data  = wt_img[idx];
            if (weight_valid && weight_ready) idx++;
            tick;
            guard++;
        end
        pixel_valid = 1'b0;
        chk("weight_count", idx, k * 9);
        chk("w_rdy_after_load", weight_ready, 0);

        idx = 0;
        guard = 0;
        weight_valid = 1'b1;
        weight_data = '1;
        while (idx < r * c && guard < 8000) begin
            if (idx == abort_at) begin
                pixel_valid  = 1'b0;
                weight_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("abort_outputs", all_outs(), 0);
                tick;
                tick;
                rst_n = 1'b1;
                tick;
                chk("abort_idle", all_outs(), 0);
                return;
            end
            pixel_valid = ($urandom_range(0, 3) != 0);
            pixel_data  = pix_img[idx];
            if (pixel_valid && pixel_ready) idx++;
            tick;
            guard++;
        end
        pixel_valid  = 1'b0;
        weight_valid = 1'b0;
        chk("pixel_count", idx, r * c);
        chk("fetch_complete", job_fetch_complete, 1);
        tick;
        chk("fetch_complete_pulse", job_fetch_complete, 0);

        n = 0;
        guard = 0;
        stalled = 1'b0;
        last_xfer = -1;
        held = '0;
        last_idx = '0;
        while (n < nres && guard < nres * 40 + 100) begin
            result_accept = rnd_acc ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (stalled) begin
                chk("stall_valid", result_valid, 1);
                chk("stall_hold", {result_data, output_row, output_col, output_depth}, held);
            end
            if (result_valid) begin
                if (result_accept) begin
                    e = exp_q[n];
                    chk("res_data", $signed(result_data), e.data);
                    chk("res_idx", {output_row, output_col, output_depth},
                        {8'(e.row), 8'(e.col), 8'(e.k)});
                    if (!rnd_acc && last_xfer >= 0) chk("throughput", cyc - last_xfer, 11);
                    last_xfer = cyc;
                    last_res  = $signed(result_data);
                    last_idx  = {16'd0, output_row, output_col, output_depth};
                    stalled = 1'b0;
                    n++;
                end else begin
                    stalled = 1'b1;
                    held = {result_data, output_row, output_col, output_depth};
                end
            end
            tick;
            guard++;
        end
        result_accept = 1'b0;
        chk("result_count", n, nres);
        chk("last_idx", last_idx, {16'd0, 8'(r - 3), 8'(c - 3), 8'(k - 1)});
        chk("job_complete", job_complete, 1);
        chk("no_valid_in_done", result_valid, 0);

        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) begin
            tick;
            chk("complete_held", job_complete, 1);
        end
        job_complete_ack = 1'b1;
        job_start = 1'b1;
        tick;
        job_complete_ack = 1'b0;
        job_start = 1'b0;
        chk("complete_cleared", job_complete, 0);
        tick;
        chk("start_with_ack_ignored", job_accept, 0);
    endtask

    task automatic run_invalid(input int r, input int c, input int k);
        job_parameters = {104'd0, 8'(k), 8'(c), 8'(r)};
        job_start = 1'b1;
        tick;
        job_start = 1'b0;
        chk("inv_accept", job_accept, 1);
        tick;
        chk("inv_no_fetch", job_fetch_request, 0);
        chk("inv_complete", job_complete, 1);
        chk("inv_no_load", {weight_ready, pixel_ready, result_valid}, 0);
        job_complete_ack = 1'b1;
        tick;
        job_complete_ack = 1'b0;
        tick;
        chk("inv_back_idle", {job_complete, job_accept}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        job_start = 1'b1;
        job_parameters = {104'd0, 8'd2, 8'd5, 8'd5};
        job_fetch_ack = 1'b1;
        job_complete_ack = 1'b1;
        weight_valid = 1'b1;
        weight_data = '1;
        pixel_valid = 1'b1;
        pixel_data = '1;
        result_accept = 1'b1;
        last_res = 0;
        repeat (3) tick;
        chk("reset_outputs", all_outs(), 0);
        job_start = 1'b0;
        job_fetch_ack = 1'b0;
        job_complete_ack = 1'b0;
        weight_valid = 1'b0;
        pixel_valid = 1'b0;
        result_accept = 1'b0;
        rst_n = 1'b1;
        tick;
        tick;
        chk("idle_after_reset", all_outs(), 0);

        run_job(21, 21, 3, 0, 1'b0, -1);
        chk("unity_value", last_res, 18432);

        run_job(3, 3, 1, 2, 1'b0, -1);
        chk("tap_index_sum", last_res, 45);
        run_job(3, 3, 1, 3, 1'b0, -1);
        chk("sat_positive", last_res, 32767);
        run_job(3, 3, 1, 4, 1'b1, -1);
        chk("sat_negative", last_res, -32768);

        run_job(21, 21, 3, 0, 1'b1, -1);

        run_invalid(2, 5, 1);
        run_invalid(5, 2, 1);
        run_invalid(5, 5, 0);
        run_invalid(5, 5, 9);
        run_invalid(33, 5, 1);
        run_invalid(5, 33, 1);

        run_job(5, 5, 2, 1, 1'b0, 7);
        run_job(6, 7, 8, 1, 1'b1, -1);
        run_job(4, 32, 2, 5, 1'b1, -1);
        run_job(32, 4, 1, 1, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
